// File: rtl/fp_pkg.sv
// Shared encodings for the FPU datapath: rounding modes, adder states, flag indices
// and exponent-range helpers parameterised by exponent width.
package fp_pkg;

  typedef enum logic [1:0] {
    RM_RNE = 2'd0,
    RM_RTZ = 2'd1,
    RM_RDN = 2'd2,
    RM_RUP = 2'd3
  } rm_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_UNPACK,
    ST_SPECIAL,
    ST_ALIGN,
    ST_ADD,
    ST_NORM,
    ST_ROUND,
    ST_PACK,
    ST_PUT
  } state_t;

  localparam int unsigned FLAG_INX = 0;
  localparam int unsigned FLAG_UNF = 1;
  localparam int unsigned FLAG_OVF = 2;
  localparam int unsigned FLAG_INV = 3;

  function automatic int fp_bias(input int unsigned ew);
    return (1 << (ew - 1)) - 1;
  endfunction

  function automatic int fp_emin(input int unsigned ew);
    return 1 - fp_bias(ew);
  endfunction

  function automatic int fp_emax(input int unsigned ew);
    return fp_bias(ew);
  endfunction

endpackage

// File: rtl/fp_addsub_if.sv
// Operand and result stb/ack bundles between the FPU issue logic and the adder.
interface fp_addsub_if #(
  parameter int unsigned EW = 8,
  parameter int unsigned MW = 23
);
  localparam int unsigned W = 1 + EW + MW;

  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_op;
  logic [1:0]   in_rm;
  logic         in_stb;
  logic         in_ack;
  logic [W-1:0] out_z;
  logic [3:0]   out_flags;
  logic         out_stb;
  logic         out_ack;

  modport master (
    output in_a, in_b, in_op, in_rm, in_stb, out_ack,
    input  in_ack, out_z, out_flags, out_stb
  );

  modport slave (
    input  in_a, in_b, in_op, in_rm, in_stb, out_ack,
    output in_ack, out_z, out_flags, out_stb
  );
endinterface

// File: rtl/fp_round.sv
// Rounding decision from lsb/guard/round/sticky; shared by the FPU adder and multiplier.
module fp_round
  import fp_pkg::*;
(
  input  logic lsb,
  input  logic g,
  input  logic r,
  input  logic s,
  input  logic sign,
  input  rm_t  rm,
  output logic inc_c,
  output logic inexact_c
);

  always_comb begin
    inexact_c = g | r | s;
    inc_c     = 1'b0;
    case (rm)
      RM_RNE: inc_c = g & (r | s | lsb);
      RM_RTZ: inc_c = 1'b0;
      RM_RDN: inc_c = sign & inexact_c;
      RM_RUP: inc_c = ~sign & inexact_c;
      default: inc_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/fp_addsub.sv
// Multi-cycle IEEE-754 adder/subtractor with stb/ack input and output transfers.
// Define FP_ADDSUB_DENORM_EN for gradual underflow; otherwise subnormals flush to zero.
module fp_addsub
  import fp_pkg::*;
#(
  parameter int unsigned EW = 8,
  parameter int unsigned MW = 23
) (
  input logic        clk,
  input logic        rst,
  fp_addsub_if.slave bus
);

  localparam int unsigned W   = 1 + EW + MW;
  localparam int unsigned XW  = EW + 2;
  localparam int unsigned MWW = MW + 4;
  localparam int unsigned RW  = MW + 2;
  localparam logic signed [XW-1:0] BIAS = XW'(fp_bias(EW));
  localparam logic signed [XW-1:0] EMIN = XW'(fp_emin(EW));
  localparam logic signed [XW-1:0] EMAX = XW'(fp_emax(EW));
  localparam logic [W-1:0] QNAN = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};

  state_t state;
  logic [W-1:0] a_w, b_w;
  logic         op;
  rm_t          rm;
  logic         a_s, b_s, z_s;
  logic signed [XW-1:0] a_e, b_e, z_e;
  logic [MWW-1:0] a_m, b_m;
  logic [MWW:0]   z_m;
  logic           inexact;
  logic [W-1:0]   res_z;
  logic [3:0]     res_flags;
  logic           in_ack_q, out_stb_q;
  logic [W-1:0]   out_z_q;
  logic [3:0]     out_flags_q;

  assign bus.in_ack    = in_ack_q;
  assign bus.out_stb   = out_stb_q;
  assign bus.out_z     = out_z_q;
  assign bus.out_flags = out_flags_q;

  // Operand classification straight from the captured words
  logic [EW-1:0] a_exp, b_exp;
  logic [MW-1:0] a_frac, b_frac;
  logic a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
  assign a_exp  = a_w[W-2:MW];
  assign b_exp  = b_w[W-2:MW];
  assign a_frac = a_w[MW-1:0];
  assign b_frac = b_w[MW-1:0];
  assign a_nan  = (&a_exp) && (|a_frac);
  assign b_nan  = (&b_exp) && (|b_frac);
  assign a_snan = a_nan && !a_frac[MW-1];
  assign b_snan = b_nan && !b_frac[MW-1];
  assign a_inf  = (&a_exp) && !(|a_frac);
  assign b_inf  = (&b_exp) && !(|b_frac);
`ifdef FP_ADDSUB_DENORM_EN
  assign a_zero = (a_exp == '0) && (a_frac == '0);
  assign b_zero = (b_exp == '0) && (b_frac == '0);
`else
  assign a_zero = (a_exp == '0);
  assign b_zero = (b_exp == '0);
`endif

  function automatic logic [MWW-1:0] shr_sticky(input logic [MWW-1:0] m, input logic [XW-1:0] d);
    logic [MWW-1:0] lost;
    if (32'(d) >= MWW) return {{(MWW-1){1'b0}}, |m};
    lost = m & ~({MWW{1'b1}} << d);
    return (m >> d) | {{(MWW-1){1'b0}}, |lost};
  endfunction

  logic           a_big;
  logic [XW-1:0]  shamt;
  logic [MWW-1:0] aligned;
  assign a_big   = a_e > b_e;
  assign shamt   = a_big ? XW'(a_e - b_e) : XW'(b_e - a_e);
  assign aligned = shr_sticky(a_big ? b_m : a_m, shamt);

  logic          rnd_inc, rnd_inx;
  logic [RW-1:0] rounded;
  logic [EW-1:0] z_eb;
  fp_round u_round (
    .lsb(z_m[3]), .g(z_m[2]), .r(z_m[1]), .s(z_m[0]),
    .sign(z_s), .rm(rm), .inc_c(rnd_inc), .inexact_c(rnd_inx)
  );
  assign rounded = {1'b0, z_m[MW+3:3]} + RW'(rnd_inc);
  assign z_eb    = EW'(z_e + BIAS);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      a_w <= '0; b_w <= '0; op <= 1'b0; rm <= RM_RNE;
      a_s <= 1'b0; b_s <= 1'b0; z_s <= 1'b0;
      a_e <= '0; b_e <= '0; z_e <= '0;
      a_m <= '0; b_m <= '0; z_m <= '0;
      inexact <= 1'b0; res_z <= '0; res_flags <= '0;
      in_ack_q <= 1'b0; out_stb_q <= 1'b0; out_z_q <= '0; out_flags_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_ack_q && bus.in_stb) begin
            a_w <= bus.in_a; b_w <= bus.in_b; op <= bus.in_op; rm <= rm_t'(bus.in_rm);
            in_ack_q <= 1'b0;
            state <= ST_UNPACK;
          end else begin
            in_ack_q <= 1'b1;
          end
        end
        ST_UNPACK: begin
          a_s <= a_w[W-1];
          b_s <= b_w[W-1] ^ op;
          a_e <= $signed({2'b00, a_exp}) - BIAS;
          b_e <= $signed({2'b00, b_exp}) - BIAS;
          a_m <= {1'b0, a_frac, 3'b000};
          b_m <= {1'b0, b_frac, 3'b000};
          state <= ST_SPECIAL;
        end
        ST_SPECIAL: begin
          res_flags <= '0;
          state <= ST_PUT;
          if (a_nan || b_nan) begin
            res_z <= QNAN;
            res_flags <= {a_snan | b_snan, 3'b000};
          end else if (a_inf && b_inf && (a_s != b_s)) begin
            res_z <= QNAN;
            res_flags <= 4'b1000;
          end else if (a_inf) res_z <= {a_s, a_w[W-2:0]};
          else if (b_inf) res_z <= {b_s, b_w[W-2:0]};
          else if (a_zero && b_zero)
            res_z <= {(a_s & b_s) | ((a_s ^ b_s) & (rm == RM_RDN)), {(W-1){1'b0}}};
          else if (a_zero) res_z <= {b_s, b_w[W-2:0]};
          else if (b_zero) res_z <= {a_s, a_w[W-2:0]};
          else begin
            // Subnormals carry emin with a clear hidden bit
            a_e <= (a_exp == '0) ? EMIN : a_e;
            b_e <= (b_exp == '0) ? EMIN : b_e;
            a_m[MWW-1] <= (a_exp != '0);
            b_m[MWW-1] <= (b_exp != '0);
            state <= ST_ALIGN;
          end
        end
        ST_ALIGN: begin
          if (a_big) begin
            b_m <= aligned; b_e <= a_e;
          end else begin
            a_m <= aligned; a_e <= b_e;
          end
          state <= ST_ADD;
        end
        ST_ADD: begin
          z_e <= a_e;
          if (a_s == b_s) begin
            z_m <= {1'b0, a_m} + {1'b0, b_m}; z_s <= a_s;
          end else if (a_m >= b_m) begin
            z_m <= {1'b0, a_m - b_m}; z_s <= a_s;
          end else begin
            z_m <= {1'b0, b_m - a_m}; z_s <= b_s;
          end
          state <= ST_NORM;
        end
        ST_NORM: begin
          if (z_m[MWW]) begin
            z_m <= {1'b0, z_m[MWW:2], z_m[1] | z_m[0]};
            z_e <= z_e + XW'(1);
          end else if (z_m != '0 && !z_m[MWW-1] && z_e > EMIN) begin
            z_m <= z_m << 1;
            z_e <= z_e - XW'(1);
          end else begin
            state <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          inexact <= rnd_inx;
          if (rounded[RW-1]) begin
            z_m <= {1'b0, rounded[RW-1:1], 3'b000};
            z_e <= z_e + XW'(1);
          end else begin
            z_m <= {1'b0, rounded[RW-2:0], 3'b000};
          end
          state <= ST_PACK;
        end
        ST_PACK: begin
          if (z_m == '0) begin
            res_z <= {rm == RM_RDN, {(W-1){1'b0}}};
            res_flags <= '0;
          end else if (z_e > EMAX) begin
            res_flags <= 4'b0101;
            if (rm == RM_RNE || (rm == RM_RUP && !z_s) || (rm == RM_RDN && z_s))
              res_z <= {z_s, {EW{1'b1}}, {MW{1'b0}}};
            else
              res_z <= {z_s, {(EW-1){1'b1}}, 1'b0, {MW{1'b1}}};
          end else if (!z_m[MWW-1]) begin
`ifdef FP_ADDSUB_DENORM_EN
            res_z <= {z_s, {EW{1'b0}}, z_m[MW+2:3]};
            res_flags <= {2'b00, inexact, inexact};
`else
            res_z <= {z_s, {(W-1){1'b0}}};
            res_flags <= 4'b0011;
`endif
          end else begin
            res_z <= {z_s, z_eb, z_m[MW+2:3]};
            res_flags <= {3'b000, inexact};
          end
          state <= ST_PUT;
        end
        ST_PUT: begin
          if (!out_stb_q) begin
            out_stb_q <= 1'b1;
            out_z_q <= res_z;
            out_flags_q <= res_flags;
          end else if (bus.out_ack) begin
            out_stb_q <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_addsub.sv
// Vector-table bench for fp_addsub (single and half precision) with an expected-result queue.
module tb_fp_addsub;
  import fp_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp_addsub_if #(.EW(8), .MW(23)) b32 ();
  fp_addsub_if #(.EW(5), .MW(10)) b16 ();

  fp_addsub #(.EW(8), .MW(23)) dut32 (.clk(clk), .rst(rst), .bus(b32));
  fp_addsub #(.EW(5), .MW(10)) dut16 (.clk(clk), .rst(rst), .bus(b16));

  typedef struct {
    bit          sel;
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [1:0]  rm;
    logic [31:0] z;
    logic [3:0]  flags;
    int          lat;
    int          hold;
  } vec_t;

  typedef struct {
    logic [31:0] z;
    logic [3:0]  flags;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic drive(input bit sel, input logic [31:0] a, input logic [31:0] b,
                       input logic op, input logic [1:0] rm, input logic stb);
    if (sel) begin
      b16.in_a = a[15:0]; b16.in_b = b[15:0]; b16.in_op = op; b16.in_rm = rm; b16.in_stb = stb;
    end else begin
      b32.in_a = a; b32.in_b = b; b32.in_op = op; b32.in_rm = rm; b32.in_stb = stb;
    end
  endtask

  task automatic set_ack(input bit sel, input logic v);
    if (sel) b16.out_ack = v;
    else b32.out_ack = v;
  endtask

  function automatic logic get_in_ack(input bit sel);
    return sel ? b16.in_ack : b32.in_ack;
  endfunction

  function automatic logic get_stb(input bit sel);
    return sel ? b16.out_stb : b32.out_stb;
  endfunction

  function automatic logic [31:0] get_z(input bit sel);
    return sel ? {16'h0000, b16.out_z} : b32.out_z;
  endfunction

  function automatic logic [3:0] get_flags(input bit sel);
    return sel ? b16.out_flags : b32.out_flags;
  endfunction

  function automatic vec_t mk(input bit sel, input logic [31:0] a, input logic [31:0] b,
                              input logic op, input rm_t rm, input logic [31:0] z,
                              input logic [3:0] flags, input int lat, input int hold);
    vec_t v;
    v.sel = sel; v.a = a; v.b = b; v.op = op; v.rm = rm;
    v.z = z; v.flags = flags; v.lat = lat; v.hold = hold;
    return v;
  endfunction

  task automatic wait_ready(input bit sel, input string name);
    int waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!get_in_ack(sel) && waited < 50);
    check({name, " ready"}, 32'(get_in_ack(sel)), 32'd1);
  endtask

  task automatic run(input vec_t v, input string name);
    exp_t e;
    int lat;
    wait_ready(v.sel, name);
    drive(v.sel, v.a, v.b, v.op, v.rm, 1'b1);
    @(posedge clk);
    sb.push_back('{z: v.z, flags: v.flags});
    #1;
    drive(v.sel, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0);
    check({name, " ack_low"}, 32'(get_in_ack(v.sel)), 32'd0);
    lat = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (get_stb(v.sel)) begin
        lat = i;
        break;
      end
    end
    check({name, " latency"}, 32'(lat), 32'(v.lat));
    e = sb.pop_front();
    if (lat == 0) return;
    check({name, " z"}, get_z(v.sel), e.z);
    check({name, " flags"}, 32'(get_flags(v.sel)), 32'(e.flags));
    check({name, " busy"}, 32'(get_in_ack(v.sel)), 32'd0);
    for (int h = 0; h < v.hold; h++) begin
      @(posedge clk);
      #1;
      check({name, " hold_stb"}, 32'(get_stb(v.sel)), 32'd1);
      check({name, " hold_z"}, get_z(v.sel), e.z);
      check({name, " hold_ack"}, 32'(get_in_ack(v.sel)), 32'd0);
    end
    set_ack(v.sel, 1'b1);
    @(posedge clk);
    #1;
    set_ack(v.sel, 1'b0);
    check({name, " stb_drop"}, 32'(get_stb(v.sel)), 32'd0);
    check({name, " turn_ack0"}, 32'(get_in_ack(v.sel)), 32'd0);
    @(posedge clk);
    #1;
    check({name, " turn_ack1"}, 32'(get_in_ack(v.sel)), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    drive(1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0);
    drive(1'b1, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0);
    set_ack(1'b0, 1'b0);
    set_ack(1'b1, 1'b0);

    vecs.push_back(mk(0, 32'h3F800000, 32'h3F800000, 0, RM_RNE, 32'h40000000, 4'b0000, 9, 0));
    vecs.push_back(mk(0, 32'h3F800000, 32'h3F800000, 1, RM_RNE, 32'h00000000, 4'b0000, 8, 0));
    vecs.push_back(mk(0, 32'h3F800000, 32'h3F800000, 1, RM_RDN, 32'h80000000, 4'b0000, 8, 0));
    vecs.push_back(mk(0, 32'h7F7FFFFF, 32'h7F7FFFFF, 0, RM_RNE, 32'h7F800000, 4'b0101, 9, 0));
    vecs.push_back(mk(0, 32'h7F7FFFFF, 32'h7F7FFFFF, 0, RM_RTZ, 32'h7F7FFFFF, 4'b0101, 9, 0));
    vecs.push_back(mk(0, 32'h7F7FFFFF, 32'h7F7FFFFF, 0, RM_RDN, 32'h7F7FFFFF, 4'b0101, 9, 0));
    vecs.push_back(mk(0, 32'h7F800000, 32'h7F800000, 1, RM_RNE, 32'h7FC00000, 4'b1000, 3, 5));
    vecs.push_back(mk(0, 32'h3F800000, 32'h33800000, 0, RM_RNE, 32'h3F800000, 4'b0001, 8, 0));
    vecs.push_back(mk(0, 32'h3F800000, 32'h33800000, 0, RM_RUP, 32'h3F800001, 4'b0001, 8, 0));
    vecs.push_back(mk(0, 32'h3F800001, 32'h33800000, 0, RM_RNE, 32'h3F800002, 4'b0001, 8, 0));
    vecs.push_back(mk(0, 32'h40400000, 32'h3F800000, 1, RM_RNE, 32'h40000000, 4'b0000, 8, 0));
    vecs.push_back(mk(0, 32'h3F800000, 32'hBFC00000, 0, RM_RNE, 32'hBF000000, 4'b0000, 9, 0));
    vecs.push_back(mk(0, 32'h3F800001, 32'h3F800000, 1, RM_RNE, 32'h34000000, 4'b0000, 31, 0));
    vecs.push_back(mk(0, 32'h7FA00000, 32'h3F800000, 0, RM_RNE, 32'h7FC00000, 4'b1000, 3, 0));
    vecs.push_back(mk(0, 32'h7FC00001, 32'h00000000, 0, RM_RNE, 32'h7FC00000, 4'b0000, 3, 0));
    vecs.push_back(mk(0, 32'hFF800000, 32'h3F800000, 0, RM_RNE, 32'hFF800000, 4'b0000, 3, 0));
    vecs.push_back(mk(0, 32'h00000000, 32'h3F800000, 1, RM_RNE, 32'hBF800000, 4'b0000, 3, 0));
    vecs.push_back(mk(0, 32'h80000000, 32'h80000000, 0, RM_RNE, 32'h80000000, 4'b0000, 3, 0));
`ifdef FP_ADDSUB_DENORM_EN
    vecs.push_back(mk(0, 32'h00000001, 32'h00000001, 0, RM_RNE, 32'h00000002, 4'b0000, 8, 0));
    vecs.push_back(mk(0, 32'h00800001, 32'h00800000, 1, RM_RNE, 32'h00000001, 4'b0000, 8, 0));
`else
    vecs.push_back(mk(0, 32'h00000001, 32'h00000001, 0, RM_RNE, 32'h00000000, 4'b0000, 3, 0));
    vecs.push_back(mk(0, 32'h00800001, 32'h00800000, 1, RM_RNE, 32'h00000000, 4'b0011, 8, 0));
`endif
    vecs.push_back(mk(1, 32'h00003C00, 32'h00003C00, 0, RM_RNE, 32'h00004000, 4'b0000, 9, 0));
    vecs.push_back(mk(1, 32'h00007BFF, 32'h00007BFF, 0, RM_RNE, 32'h00007C00, 4'b0101, 9, 0));

    // Reset values while reset is held
    #2;
    rst = 1'b0;
    #1;
    check("rst in_ack", 32'(get_in_ack(0)), 32'd0);
    check("rst out_stb", 32'(get_stb(0)), 32'd0);
    check("rst out_z", get_z(0), 32'h0);
    check("rst out_flags", 32'(get_flags(0)), 32'h0);
    check("rst16 in_ack", 32'(get_in_ack(1)), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rel in_ack", 32'(get_in_ack(0)), 32'd1);
    check("rel16 in_ack", 32'(get_in_ack(1)), 32'd1);

    foreach (vecs[i]) run(vecs[i], $sformatf("vec%0d", i));

    // Reset while the normaliser is still shifting a long cancellation
    wait_ready(0, "midrst");
    drive(0, 32'h3F800001, 32'h3F800000, 1'b1, RM_RNE, 1'b1);
    @(posedge clk);
    #1;
    drive(0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0);
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst out_stb", 32'(get_stb(0)), 32'd0);
    check("midrst in_ack", 32'(get_in_ack(0)), 32'd0);
    check("midrst out_z", get_z(0), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("midrst held stb", 32'(get_stb(0)), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst in_ack rise", 32'(get_in_ack(0)), 32'd1);
    check("midrst no stb", 32'(get_stb(0)), 32'd0);
    run(vecs[0], "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
